// File: rtl/data_mem_responder.sv
// Data-memory target: latches one load/write request, waits WAIT_CYCLES, commits write-then-read,
// and pulses ld_valid. Optional bounds checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module data_mem_responder #(
  parameter int    DEPTH       = 256,
  parameter int    WAIT_CYCLES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        is_load,
  input  logic        is_write,
  input  logic [8:0]  load_addr,
  input  logic [8:0]  write_addr,
  input  logic [15:0] data,
  output logic        mem_ready,
  output logic        ld_valid,
  output logic [15:0] ld_data,
  output logic        addr_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Handshake: a request is accepted on any posedge where mem_ready=1 and is_load|is_write=1;
  // requests presented while mem_ready=0 are dropped. ld_valid is a one-cycle pulse, no back-pressure.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_ld;
  logic        r_wr;
  logic [8:0]  r_laddr;
  logic [8:0]  r_waddr;
  logic [15:0] r_data;
  logic        r_ready;
  logic        r_vld;
  logic [15:0] r_ld_data;
  logic        r_err;
  logic [15:0] r_mem [DEPTH];

  logic [AW-1:0] w_lidx;
  logic [AW-1:0] w_widx;
  logic          w_commit;
  logic          w_lerr;
  logic          w_werr;
  logic          w_do_wr;
  logic [15:0]   w_rd_val;
  logic          w_err_hit;
  logic          w_unused_hi;

  assign w_lidx      = r_laddr[AW-1:0];
  assign w_widx      = r_waddr[AW-1:0];
  assign w_unused_hi = ^{r_laddr, r_waddr};
  assign w_commit    = (r_state == S_WAIT) && (r_cnt == 4'd0);

`ifdef DMEM_BOUNDS_CHECK_EN
  assign w_lerr = ({1'b0, r_laddr} >= 10'(DEPTH));
  assign w_werr = ({1'b0, r_waddr} >= 10'(DEPTH));
`else
  assign w_lerr = 1'b0;
  assign w_werr = 1'b0;
`endif

  assign w_do_wr   = r_wr && !w_werr;
  assign w_err_hit = (r_ld && w_lerr) || (r_wr && w_werr);

  // Write-first: a load to the address being written in the same commit sees the new data.
  always_comb begin
    w_rd_val = r_mem[w_lidx];
    if (w_lerr)
      w_rd_val = 16'hDEAD;
    else if (w_do_wr && (w_widx == w_lidx))
      w_rd_val = r_data;
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_ld      <= 1'b0;
      r_wr      <= 1'b0;
      r_laddr   <= 9'd0;
      r_waddr   <= 9'd0;
      r_data    <= 16'h0;
      r_ready   <= 1'b1;
      r_vld     <= 1'b0;
      r_ld_data <= 16'h0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (is_load || is_write) begin
            r_ld    <= is_load;
            r_wr    <= is_write;
            r_laddr <= load_addr;
            r_waddr <= write_addr;
            r_data  <= data;
            r_cnt   <= 4'(WAIT_CYCLES);
            r_ready <= 1'b0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_vld   <= r_ld;
            r_err   <= w_err_hit;
            if (r_ld)
              r_ld_data <= w_rd_val;
            r_state <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RESP: begin
          r_vld   <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_vld   <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Storage is intentionally not reset; a reset during WAIT leaves r_state=IDLE so nothing commits.
  always_ff @(posedge ck) begin
    if (w_commit && w_do_wr)
      r_mem[w_widx] <= r_data;
  end

  assign mem_ready = r_ready;
  assign ld_valid  = r_vld;
  assign ld_data   = r_ld_data;
  assign dbg_state = r_state;
`ifdef DMEM_BOUNDS_CHECK_EN
  assign addr_err  = r_err;
`else
  assign addr_err  = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a WAIT_CYCLES=2 instance carries most tests,
// a WAIT_CYCLES=0 instance shares its inputs for the short-latency case.
module tb_data_mem_responder;

  logic        ck;
  logic        rst_n;
  logic        is_load;
  logic        is_write;
  logic [8:0]  load_addr;
  logic [8:0]  write_addr;
  logic [15:0] data;

  logic        mem_ready,  ld_valid,  addr_err;
  logic [15:0] ld_data;
  logic [1:0]  dbg_state;
  logic        mem_ready1, ld_valid1, addr_err1;
  logic [15:0] ld_data1;
  logic [1:0]  dbg_state1;

  int n_checks = 0;
  int n_fail   = 0;

  int          lat;
  int          vcnt;
  logic [15:0] rd;
  logic        err;

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) u_dut (
    .ck(ck), .rst_n(rst_n), .is_load(is_load), .is_write(is_write),
    .load_addr(load_addr), .write_addr(write_addr), .data(data),
    .mem_ready(mem_ready), .ld_valid(ld_valid), .ld_data(ld_data),
    .addr_err(addr_err), .dbg_state(dbg_state)
  );

  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) u_dut_w0 (
    .ck(ck), .rst_n(rst_n), .is_load(is_load), .is_write(is_write),
    .load_addr(load_addr), .write_addr(write_addr), .data(data),
    .mem_ready(mem_ready1), .ld_valid(ld_valid1), .ld_data(ld_data1),
    .addr_err(addr_err1), .dbg_state(dbg_state1)
  );

  // clock / reset
  initial ck = 1'b0;
  always #5 ck = ~ck;

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // driver: present one request for exactly one accepting edge
  task automatic issue(input logic ld, input logic wr, input logic [8:0] la,
                       input logic [8:0] wa, input logic [15:0] d);
    int k;
    k = 0;
    while (!(mem_ready && mem_ready1) && k < 30) begin
      @(negedge ck);
      k++;
    end
    if (k >= 30) check("issue_timeout", 32'd0, 32'd1);
    is_load    = ld;
    is_write   = wr;
    load_addr  = la;
    write_addr = wa;
    data       = d;
    @(posedge ck);
    #1;
    is_load  = 1'b0;
    is_write = 1'b0;
  endtask

  // collect the response of the WAIT_CYCLES=2 instance; k counts negedges after the accept edge
  task automatic collect();
    lat  = 0;
    vcnt = 0;
    err  = 1'b0;
    rd   = 16'h0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge ck);
      if (ld_valid) begin
        vcnt++;
        if (lat == 0) begin
          lat = k;
          rd  = ld_data;
        end
      end
      if (addr_err) err = 1'b1;
      if (mem_ready) return;
    end
    check("collect_timeout", 32'd0, 32'd1);
  endtask

  task automatic txn(input logic ld, input logic wr, input logic [8:0] la,
                     input logic [8:0] wa, input logic [15:0] d);
    issue(ld, wr, la, wa, d);
    collect();
  endtask

  int          lat1;
  logic [15:0] rd1;
  int          pulses, p_first, p_second, ready_cnt, good_data;

  initial begin
    rst_n      = 1'b0;
    is_load    = 1'b0;
    is_write   = 1'b0;
    load_addr  = 9'd0;
    write_addr = 9'd0;
    data       = 16'h0;
    repeat (2) @(negedge ck);
    check("rst_ready",    32'(mem_ready), 32'd1);
    check("rst_valid",    32'(ld_valid),  32'd0);
    check("rst_data",     32'(ld_data),   32'h0);
    check("rst_err",      32'(addr_err),  32'd0);
    check("rst_state",    32'(dbg_state), 32'd0);
    check("rst_ready_w0", 32'(mem_ready1), 32'd1);
    rst_n = 1'b1;
    @(negedge ck);

    // preload known contents
    txn(1'b0, 1'b1, 9'd0, 9'h010, 16'h1111);
    check("wr_only_no_valid", 32'(vcnt), 32'd0);
    txn(1'b0, 1'b1, 9'd0, 9'h021, 16'h0001);
    txn(1'b0, 1'b1, 9'd0, 9'h0FF, 16'h00FF);

    // T1: reset during WAIT aborts the write
    issue(1'b0, 1'b1, 9'd0, 9'h010, 16'h1234);
    @(negedge ck);
    check("t1_in_wait", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t1_rst_ready", 32'(mem_ready), 32'd1);
    check("t1_rst_valid", 32'(ld_valid),  32'd0);
    repeat (2) begin
      @(negedge ck);
      check("t1_rst_hold_ready", 32'(mem_ready), 32'd1);
      check("t1_rst_hold_valid", 32'(ld_valid),  32'd0);
    end
    rst_n = 1'b1;
    @(negedge ck);
    txn(1'b1, 1'b0, 9'h010, 9'd0, 16'h0);
    check("t1_old_value", 32'(rd),   32'h1111);
    check("t1_valid_cnt", 32'(vcnt), 32'd1);

    // reset during RESP drops ld_valid immediately
    issue(1'b1, 1'b0, 9'h010, 9'd0, 16'h0);
    repeat (4) @(negedge ck);
    check("rresp_valid_hi", 32'(ld_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rresp_valid_drop", 32'(ld_valid), 32'd0);
    @(negedge ck);
    rst_n = 1'b1;
    @(negedge ck);

    // T2: write then load, latency and pulse width
    txn(1'b0, 1'b1, 9'd0, 9'h005, 16'hBEEF);
    txn(1'b1, 1'b0, 9'h005, 9'd0, 16'h0);
    check("t2_latency", 32'(lat),  32'd4);
    check("t2_data",    32'(rd),   32'hBEEF);
    check("t2_width",   32'(vcnt), 32'd1);

    // write-only leaves ld_data alone
    txn(1'b0, 1'b1, 9'd0, 9'h030, 16'h5555);
    check("wo_no_valid", 32'(vcnt),    32'd0);
    check("wo_ld_hold",  32'(ld_data), 32'hBEEF);

    // T3: combined requests
    txn(1'b1, 1'b1, 9'h020, 9'h020, 16'hA5A5);
    check("t3_same_addr", 32'(rd), 32'hA5A5);
    txn(1'b1, 1'b1, 9'h021, 9'h020, 16'hA5A5);
    check("t3_diff_addr", 32'(rd), 32'h0001);
    txn(1'b1, 1'b0, 9'h020, 9'd0, 16'h0);
    check("t3_readback", 32'(rd), 32'hA5A5);

    // T5: WAIT_CYCLES=0 instance responds on the cycle after accept+1
    issue(1'b1, 1'b0, 9'h005, 9'd0, 16'h0);
    lat1 = 0;
    rd1  = 16'h0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge ck);
      if (ld_valid1 && lat1 == 0) begin
        lat1 = k;
        rd1  = ld_data1;
      end
    end
    check("t5_latency", 32'(lat1), 32'd2);
    check("t5_data",    32'(rd1),  32'hBEEF);

    // T4: load held high for 20 cycles
    is_load   = 1'b1;
    load_addr = 9'h005;
    @(posedge ck);
    #1;
    pulses = 0; p_first = 0; p_second = 0; ready_cnt = 0; good_data = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge ck);
      if (ld_valid) begin
        pulses++;
        if (ld_data == 16'hBEEF) good_data++;
        if (p_first == 0) p_first = k;
        else if (p_second == 0) p_second = k;
      end
      if (mem_ready) ready_cnt++;
    end
    is_load = 1'b0;
    check("t4_pulses",   32'(pulses),    32'd4);
    check("t4_first",    32'(p_first),   32'd4);
    check("t4_interval", 32'(p_second - p_first), 32'd5);
    check("t4_ready",    32'(ready_cnt), 32'd4);
    check("t4_data",     32'(good_data), 32'd4);
    repeat (6) @(negedge ck);

    // T6: out-of-range address
    txn(1'b0, 1'b1, 9'd0, 9'h1FF, 16'h7777);
`ifdef DMEM_BOUNDS_CHECK_EN
    check("t6_wr_err", 32'(err), 32'd1);
    txn(1'b1, 1'b0, 9'h1FF, 9'd0, 16'h0);
    check("t6_ld_err",  32'(err), 32'd1);
    check("t6_ld_dead", 32'(rd),  32'hDEAD);
    txn(1'b1, 1'b0, 9'h0FF, 9'd0, 16'h0);
    check("t6_ff_kept", 32'(rd),  32'h00FF);
    check("t6_ff_noerr", 32'(err), 32'd0);
`else
    check("t6_wr_err", 32'(err), 32'd0);
    txn(1'b1, 1'b0, 9'h1FF, 9'd0, 16'h0);
    check("t6_ld_wrap", 32'(rd),  32'h7777);
    check("t6_ld_err",  32'(err), 32'd0);
    txn(1'b1, 1'b0, 9'h0FF, 9'd0, 16'h0);
    check("t6_ff_wrap", 32'(rd),  32'h7777);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
